exec_unit: RTL and testbench

Execute/writeback stage of TinyCPU, sitting directly upstream of the 8x8 register file. It accepts one decoded operation per handshake with both source operands already read from the register file's async read ports. It computes the result, single-cycle for ALU ops and iterative shift-add for MUL, and drives the register file's write port (`we`/`w_addr`/`w_data`) with a one-cycle write pulse. It also maintains zero/carry flags for the sequencer.

---
 rtl/exec_unit.sv | 144 ++++++++++++++
 tb/tb_exec_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute/writeback stage: single-cycle ALU ops plus iterative shift-add MUL,
// driving a one-cycle register file write pulse and zero/carry flags.
module exec_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [ADDR_W-1:0] in_dst,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              flag_z,
   output logic              flag_c,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   // Handshake: an op transfers on a rising edge where in_valid && in_ready;
   // in_ready depends only on state, and inputs are ignored while it is low.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_WB = 2'd2} state_t;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                          OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;
   localparam int CW = $clog2(DATA_W) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   state_t                state_q, state_d;
   logic [2*DATA_W-1:0]   a_q, a_d, acc_q, acc_d, mul_sum;
   logic [DATA_W-1:0]     b_q, b_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_W-1:0]     dst_q, dst_d, wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]     wb_data_q, wb_data_d, alu_res;
   logic                  fz_q, fz_d, fc_q, fc_d, alu_c;
   logic [DATA_W:0]       sum;

   always_comb begin
      sum     = {1'b0, in_a} + {1'b0, in_b};
      alu_res = '0;
      alu_c   = 1'b0;
      case (in_op)
         OP_ADD: begin alu_res = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
         OP_SUB: begin alu_res = in_a - in_b;     alu_c = (in_a < in_b); end
         OP_AND: alu_res = in_a & in_b;
         OP_OR:  alu_res = in_a | in_b;
         OP_XOR: alu_res = in_a ^ in_b;
         OP_SHL: begin alu_res = {in_a[DATA_W-2:0], 1'b0}; alu_c = in_a[DATA_W-1]; end
         OP_SHR: begin alu_res = {1'b0, in_a[DATA_W-1:1]}; alu_c = in_a[0]; end
         default: ;
      endcase
   end

   assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      dst_d     = dst_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      fz_d      = fz_q;
      fc_d      = fc_q;
      case (state_q)
         S_MUL: begin
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            acc_d = mul_sum;
            cnt_d = cnt_q + CW'(1);
            // Final iteration writes its own partial sum straight into the WB registers.
            if (cnt_q == LAST) begin
               state_d   = S_WB;
               wb_addr_d = dst_q;
               wb_data_d = mul_sum[DATA_W-1:0];
               fz_d      = (mul_sum[DATA_W-1:0] == '0);
               fc_d      = |mul_sum[2*DATA_W-1:DATA_W];
            end
         end
         default: begin
            if (in_valid) begin
               if (in_op == OP_MUL) begin
                  state_d = S_MUL;
                  a_d     = {{DATA_W{1'b0}}, in_a};
                  b_d     = in_b;
                  acc_d   = '0;
                  cnt_d   = '0;
                  dst_d   = in_dst;
               end else begin
                  state_d   = S_WB;
                  wb_addr_d = in_dst;
                  wb_data_d = alu_res;
                  fz_d      = (alu_res == '0);
                  fc_d      = alu_c;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         dst_q     <= '0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         fz_q      <= 1'b0;
         fc_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         dst_q     <= dst_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         fz_q      <= fz_d;
         fc_q      <= fc_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) || (state_q == S_WB);
   assign busy      = (state_q == S_MUL);
   assign wb_we     = (state_q == S_WB);
   assign wb_addr   = wb_addr_q;
   assign wb_data   = wb_data_q;
   assign flag_z    = fz_q;
   assign flag_c    = fc_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed plus short random bench for exec_unit with an expected-writeback queue.
module tb_exec_unit;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int EW = ADDR_W + DATA_W + 2;

   logic              clk, reset_n, in_valid, in_ready, wb_we, flag_z, flag_c, busy;
   logic [2:0]        in_op;
   logic [ADDR_W-1:0] in_dst, wb_addr;
   logic [DATA_W-1:0] in_a, in_b, wb_data;
   logic [1:0]        state_dbg;

   int checks = 0;
   int failures = 0;
   int writes = 0;
   int waited = 0;
   logic [EW-1:0] exp_q[$];

   exec_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_dst(in_dst), .in_a(in_a), .in_b(in_b),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {z, c, data} computed with wide arithmetic.
   function automatic logic [DATA_W+1:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] w;
      logic [7:0]  r;
      logic        c;
      w = 16'd0;
      r = 8'd0;
      c = 1'b0;
      case (op)
         3'd0: begin w = 16'(a) + 16'(b); r = w[7:0]; c = w[8]; end
         3'd1: begin r = a - b; c = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin w = 16'(a) * 16'd2; r = w[7:0]; c = w[8]; end
         3'd6: begin r = a / 8'd2; c = a[0]; end
         default: begin w = 16'(a) * 16'(b); r = w[7:0]; c = (w[15:8] != 8'd0); end
      endcase
      return {(r == 8'd0), c, r};
   endfunction

   // driver
   task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] dst,
                       input logic [7:0] a, input logic [7:0] b, input bit track);
      @(negedge clk);
      in_valid = 1'b1;
      in_op = op;
      in_dst = dst;
      in_a = a;
      in_b = b;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk);
         if (track) exp_q.push_back({dst, model(op, a, b)});
      end
      #1 in_valid = 1'b0;
   endtask

   // scoreboard: compare each write pulse against the head of the queue
   always @(negedge clk) begin
      if (reset_n && wb_we) begin
         writes++;
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", 32'd1, 32'd0);
         end else begin
            chk("wb_addr_z_c_data", 32'({wb_addr, flag_z, flag_c, wb_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int w0;
      reset_n = 1'b1;
      in_valid = 1'b0;
      in_op = '0;
      in_dst = '0;
      in_a = '0;
      in_b = '0;
      #3 reset_n = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_outs", 32'({busy, wb_we, wb_addr, wb_data, flag_z, flag_c}), 32'd0);
      #20 reset_n = 1'b1;

      // ADD latency and hold behaviour
      send(3'd0, 3'd3, 8'hF0, 8'h20, 1'b1);
      chk("add_lat_we", 32'(wb_we), 32'd1);
      chk("add_lat_data", 32'({wb_addr, flag_z, flag_c, wb_data}), 32'({3'd3, 1'b0, 1'b1, 8'h10}));
      @(negedge clk);
      @(negedge clk);
      chk("add_we_drop", 32'(wb_we), 32'd0);
      chk("add_hold", 32'({wb_addr, flag_c, wb_data}), 32'({3'd3, 1'b1, 8'h10}));

      // back-to-back SUBs
      send(3'd1, 3'd1, 8'h05, 8'h05, 1'b1);
      send(3'd1, 3'd2, 8'h03, 8'h05, 1'b1);
      chk("sub_b2b_nowait", 32'(waited), 32'd0);
      chk("sub_b2b_we", 32'(wb_we), 32'd1);

      // MUL latency
      send(3'd7, 3'd7, 8'h0C, 8'h0D, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mul_busy", 32'({busy, in_ready, wb_we}), 32'({1'b1, 1'b0, 1'b0}));
      end
      @(negedge clk);
      chk("mul_wb", 32'({busy, wb_we, wb_data}), 32'({1'b0, 1'b1, 8'h9C}));
      send(3'd7, 3'd5, 8'h10, 8'h10, 1'b1);
      repeat (10) @(negedge clk);

      send(3'd5, 3'd1, 8'h81, 8'h00, 1'b1);
      send(3'd6, 3'd2, 8'h01, 8'h00, 1'b1);
      send(3'd4, 3'd4, 8'hAA, 8'hAA, 1'b1);
      send(3'd2, 3'd6, 8'hF0, 8'h3C, 1'b1);
      send(3'd3, 3'd0, 8'h00, 8'h00, 1'b1);
      repeat (3) @(negedge clk);

      // reset in the middle of a MUL
      w0 = writes;
      send(3'd7, 3'd2, 8'hFF, 8'hFF, 1'b0);
      repeat (4) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midmul_rst_outs", 32'({busy, wb_we, wb_addr, wb_data, flag_z, flag_c}), 32'd0);
      chk("midmul_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midmul_no_write", 32'(writes - w0), 32'd0);
      chk("midmul_ready_after", 32'(in_ready), 32'd1);

      // ADD held during MUL, taken on the edge that ends the MUL's WB
      w0 = writes;
      send(3'd7, 3'd1, 8'h07, 8'h09, 1'b1);
      send(3'd0, 3'd2, 8'h11, 8'h22, 1'b1);
      chk("held_add_wait", 32'(waited), 32'd8);
      repeat (4) @(negedge clk);
      chk("held_add_writes", 32'(writes - w0), 32'd2);

      // random ops
      for (int i = 0; i < 12; i++) begin
         send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      end
      repeat (12) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
